// File: rtl/branch_predictor_gshare_if.sv
// Lookup, prediction and resolved-branch update signals of the branch predictor.
// The master drives lookups and updates, and the slave (the predictor) returns predictions.
interface branch_predictor_gshare_if;
  logic        lkp_valid;
  logic [31:0] lkp_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_taken, pred_hit, pred_target
  );

  modport slave (
    input  lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_taken, pred_hit, pred_target
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor made of a table of saturating counters and a tagged target buffer.
// It answers a lookup one cycle later, and an update trains the counters, the history and the buffer.
module branch_predictor_gshare #(
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 2,
  parameter int HIST_W    = 6,
  parameter int MODE      = 1,
  parameter int BTB_IDX_W = 4,
  parameter int TAG_W     = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  branch_predictor_gshare_if.slave  bus
);
  localparam int PT_SIZE  = 1 << IDX_W;
  localparam int BTB_SIZE = 1 << BTB_IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  logic [CNT_W-1:0]    cnt_reg [PT_SIZE];
  logic [HIST_W-1:0]   ghr_reg;
  logic [BTB_SIZE-1:0] btb_valid_reg;
  logic [TAG_W-1:0]    btb_tag_reg [BTB_SIZE];
  logic [31:0]         btb_target_reg [BTB_SIZE];

  logic        pred_valid_reg;
  logic        pred_taken_reg;
  logic        pred_hit_reg;
  logic [31:0] pred_target_reg;

  logic [IDX_W-1:0]     lkp_idx;
  logic [IDX_W-1:0]     upd_idx;
  logic [BTB_IDX_W-1:0] lkp_bidx;
  logic [BTB_IDX_W-1:0] upd_bidx;
  logic [TAG_W-1:0]     lkp_tag;
  logic [TAG_W-1:0]     upd_tag;
  logic                 lkp_hit;
  logic                 upd_fire;
  logic [CNT_W-1:0]     cnt_upd_cur;
  logic [CNT_W-1:0]     cnt_upd_next;
  logic [HIST_W:0]      ghr_shift;
  logic [HIST_W-1:0]    ghr_next;
  logic                 unused_pc_bits;

  function automatic logic [IDX_W-1:0] pt_index(input logic [31:0] pc,
                                                input logic [HIST_W-1:0] ghr);
    logic [IDX_W-1:0] pcidx;
    pcidx = pc[IDX_W+1:2];
    if (MODE == 1) return pcidx ^ IDX_W'(ghr);
    return pcidx;
  endfunction

  // Lookup and update both index with the history held before this edge.
  assign lkp_idx  = pt_index(bus.lkp_pc, ghr_reg);
  assign upd_idx  = pt_index(bus.upd_pc, ghr_reg);
  assign lkp_bidx = bus.lkp_pc[BTB_IDX_W+1:2];
  assign upd_bidx = bus.upd_pc[BTB_IDX_W+1:2];
  assign lkp_tag  = bus.lkp_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign upd_tag  = bus.upd_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign lkp_hit  = btb_valid_reg[lkp_bidx] && (btb_tag_reg[lkp_bidx] == lkp_tag);
  assign upd_fire = rdy_in && bus.upd_valid;

  assign unused_pc_bits = ^{bus.lkp_pc, bus.upd_pc};

  assign cnt_upd_cur = cnt_reg[upd_idx];
  assign ghr_shift   = {ghr_reg, bus.upd_taken};
  assign ghr_next    = ghr_shift[HIST_W-1:0];

  always_comb begin
    cnt_upd_next = cnt_upd_cur;
    if (bus.upd_taken) begin
      if (cnt_upd_cur != CNT_MAX) cnt_upd_next = cnt_upd_cur + 1'b1;
    end else if (cnt_upd_cur != '0) begin
      cnt_upd_next = cnt_upd_cur - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < PT_SIZE; i++) cnt_reg[i] <= CNT_INIT;
      ghr_reg <= '0;
    end else if (upd_fire) begin
      cnt_reg[upd_idx] <= cnt_upd_next;
      ghr_reg          <= ghr_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      btb_valid_reg <= '0;
    end else if (upd_fire && bus.upd_taken) begin
      btb_valid_reg[upd_bidx] <= 1'b1;
    end
  end

  // Tag and target need no reset because the valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (rst_in && upd_fire && bus.upd_taken) begin
      btb_tag_reg[upd_bidx]    <= upd_tag;
      btb_target_reg[upd_bidx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      pred_hit_reg    <= 1'b0;
      pred_target_reg <= '0;
    end else if (rdy_in) begin
      pred_valid_reg <= bus.lkp_valid;
      if (bus.lkp_valid) begin
        pred_hit_reg    <= lkp_hit;
        pred_taken_reg  <= lkp_hit && cnt_reg[lkp_idx][CNT_W-1];
        pred_target_reg <= lkp_hit ? btb_target_reg[lkp_bidx] : 32'd0;
      end else begin
        pred_hit_reg    <= 1'b0;
        pred_taken_reg  <= 1'b0;
        pred_target_reg <= '0;
      end
    end
  end

  assign bus.pred_valid  = pred_valid_reg;
  assign bus.pred_taken  = pred_taken_reg;
  assign bus.pred_hit    = pred_hit_reg;
  assign bus.pred_target = pred_target_reg;
endmodule
